// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter and single-access sequencer for the shared data memory

module data_mem_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_write,
    input  logic [31:0] p0_address,
    input  logic [31:0] p0_write_data,
    output logic [31:0] p0_read_data,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [31:0] p1_address,
    input  logic [31:0] p1_write_data,
    output logic [31:0] p1_read_data,
    output logic        p1_done,
    output logic        p1_err,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        sel;
    logic [31:0] sel_addr;

    // Winner selection: a lone requester always wins; a tie goes to port 0
    // in fixed-priority mode, otherwise to the port not granted last.
    always_comb begin
        sel = 1'b0;
        if (p0_req && p1_req) begin
            sel = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else begin
            sel = p1_req;
        end
        sel_addr = sel ? p1_address : p0_address;
    end

    // Next-state logic: latch the winner in IDLE, capture read data at the
    // close of ACCESS, and hold one RESP cycle for the done pulse.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    write_d      = sel ? p1_write : p0_write;
                    addr_d       = sel_addr;
                    wdata_d      = sel ? p1_write_data : p0_write_data;
                    err_d        = (sel_addr[1:0] != 2'b00);
                    state_d      = (sel_addr[1:0] != 2'b00) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q) begin
                    if (grant_q) begin
                        rdata1_d = mem_read_data;
                    end else begin
                        rdata0_d = mem_read_data;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Memory strobes and bus are decoded from the state; the bus is zero
    // outside ACCESS so the memory never sees stale addresses.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        if (state_q == ACCESS) begin
            mem_read       = ~write_q;
            mem_write      = write_q;
            mem_address    = addr_q;
            mem_write_data = wdata_q;
        end
    end

    // Completion pulses for the granted port during RESP.
    always_comb begin
        p0_done = (state_q == RESP) && !grant_q;
        p1_done = (state_q == RESP) && grant_q;
        p0_err  = p0_done && err_q;
        p1_err  = p1_done && err_q;
        busy    = (state_q != IDLE);
    end

    assign p0_read_data = rdata0_q;
    assign p1_read_data = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter

module tb_data_mem_arbiter;

    typedef struct {
        logic        is_read;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [4];
    logic        wr [4];
    logic [31:0] addr [4];
    logic [31:0] wd [4];
    logic [31:0] rd [4];
    logic        done [4];
    logic        errs [4];
    logic        busy [2];
    logic        mrd [2];
    logic        mwr [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] mrdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_mem_arbiter #(.FIXED_PRIORITY(g == 1)) u_dut (
            .clk           (clk),
            .rst           (rst[g]),
            .p0_req        (req[2*g]),
            .p0_write      (wr[2*g]),
            .p0_address    (addr[2*g]),
            .p0_write_data (wd[2*g]),
            .p0_read_data  (rd[2*g]),
            .p0_done       (done[2*g]),
            .p0_err        (errs[2*g]),
            .p1_req        (req[2*g+1]),
            .p1_write      (wr[2*g+1]),
            .p1_address    (addr[2*g+1]),
            .p1_write_data (wd[2*g+1]),
            .p1_read_data  (rd[2*g+1]),
            .p1_done       (done[2*g+1]),
            .p1_err        (errs[2*g+1]),
            .busy          (busy[g]),
            .mem_address   (maddr[g]),
            .mem_write_data(mwd[g]),
            .mem_read      (mrd[g]),
            .mem_write     (mwr[g]),
            .mem_read_data (mrdata[g])
        );
    end

    // memory stand-in for each instance
    logic [31:0] ram [2][16384];
    logic        mem_clr;
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_clr) begin
                for (int i = 0; i < 16384; i++) ram[g][i] <= 32'd0;
            end else if (mwr[g]) begin
                ram[g][maddr[g][15:2]] <= mwd[g];
            end
        end
    end
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mrdata[g] = mrd[g] ? ram[g][maddr[g][15:2]] : 32'hDEADBEEF;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [31:0] model_mem [2][16384];
    logic [31:0] model_rd [4];
    int          exp_rd_cnt [2];
    int          exp_wr_cnt [2];
    exp_t        exp_q [4][$];
    int          timeouts = 0;

    // monitor state
    int          n_pass = 0;
    int          n_total = 0;
    int          rd_str [2];
    int          wr_str [2];
    int          viol [2];
    logic [31:0] prev_rd [4];
    logic        rst_prev [2];
    logic [1:0]  chk_zero = 2'b00;
    logic        end_req = 1'b0;
    logic        end_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (chk_zero[g]) begin
                chk($sformatf("reset_outputs_zero_g%0d", g),
                    rd[2*g] | rd[2*g+1] | maddr[g] | mwd[g] |
                    {25'd0, done[2*g], done[2*g+1], errs[2*g], errs[2*g+1], busy[g], mrd[g], mwr[g]},
                    32'd0);
            end
            if (mrd[g]) rd_str[g]++;
            if (mwr[g]) wr_str[g]++;
            if (mrd[g] && mwr[g]) viol[g]++;
            if (!mrd[g] && !mwr[g] && (maddr[g] != 32'd0 || mwd[g] != 32'd0)) viol[g]++;
            for (int p = 0; p < 2; p++) begin
                int idx;
                idx = 2*g + p;
                if (rd[idx] !== prev_rd[idx] && !rst[g] && !rst_prev[g]) begin
                    if (!(done[idx] && exp_q[idx].size() > 0 && exp_q[idx][0].is_read)) viol[g]++;
                end
                prev_rd[idx] = rd[idx];
                if (errs[idx] && !done[idx]) viol[g]++;
                if (done[idx]) begin
                    if (exp_q[idx].size() == 0) begin
                        chk($sformatf("unexpected_done_g%0d_p%0d", g, p), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q[idx].pop_front();
                        chk($sformatf("err_g%0d_p%0d", g, p), {31'd0, errs[idx]}, {31'd0, e.err});
                        chk($sformatf("read_data_g%0d_p%0d", g, p), rd[idx], e.data);
                        if (e.due >= 0) chk($sformatf("latency_g%0d_p%0d", g, p), cyc, e.due);
                    end
                end
            end
            rst_prev[g] = rst[g];
        end
        if (end_req && !end_done) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("bus_violations_g%0d", g), viol[g], 32'd0);
                chk($sformatf("read_strobes_g%0d", g), rd_str[g], exp_rd_cnt[g]);
                chk($sformatf("write_strobes_g%0d", g), wr_str[g], exp_wr_cnt[g]);
            end
            for (int i = 0; i < 4; i++) chk($sformatf("pending_q%0d", i), exp_q[i].size(), 32'd0);
            chk("timeouts", timeouts, 32'd0);
            end_done = 1'b1;
        end
    end

    // issue one request, push its expected response, wait for done, release
    task automatic access(input int g, input int p, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
        int   idx;
        int   n;
        exp_t e;
        idx = 2*g + p;
        e.err = (a[1:0] != 2'b00);
        e.is_read = !w && !e.err;
        if (e.err) begin
            e.data = model_rd[idx];
        end else if (w) begin
            model_mem[g][a[15:2]] = d;
            exp_wr_cnt[g]++;
            e.data = model_rd[idx];
        end else begin
            model_rd[idx] = model_mem[g][a[15:2]];
            exp_rd_cnt[g]++;
            e.data = model_rd[idx];
        end
        e.due = (lat < 0) ? -1 : cyc + lat;
        exp_q[idx].push_back(e);
        req[idx] = 1'b1; wr[idx] = w; addr[idx] = a; wd[idx] = d;
        n = 0;
        @(negedge clk);
        while (!done[idx] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done[idx]) timeouts++;
        @(posedge clk); #1;
        req[idx] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int g);
        rst[g] = 1'b1;
        idle(2);
        rst[g] = 1'b0;
        model_rd[2*g] = 32'd0;
        model_rd[2*g+1] = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            req[i] = 0; wr[i] = 0; addr[i] = 0; wd[i] = 0; model_rd[i] = 0; prev_rd[i] = 0;
        end
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1; rst_prev[g] = 1; exp_rd_cnt[g] = 0; exp_wr_cnt[g] = 0;
            rd_str[g] = 0; wr_str[g] = 0; viol[g] = 0;
            for (int i = 0; i < 16384; i++) model_mem[g][i] = 32'd0;
        end
        mem_clr = 1'b1;
        idle(2);
        chk_zero = 2'b11;
        @(negedge clk); #1;
        chk_zero = 2'b00;
        idle(1);
        rst[0] = 0; rst[1] = 0; mem_clr = 1'b0;
        idle(2);

        // write then read back on port 0
        access(0, 0, 1'b1, 32'd4, 32'h0000FFFF, 2);
        access(0, 0, 1'b0, 32'd4, 32'd0, 2);
        idle(2);

        // tie from reset: p0 first, then p0 re-request loses to pending p1
        do_reset(0);
        idle(1);
        fork
            begin
                access(0, 0, 1'b0, 32'd8, 32'd0, 2);
                access(0, 0, 1'b1, 32'd16, 32'hA5A50001, 5);
            end
            access(0, 1, 1'b1, 32'd44, 32'hFFFF0000, 5);
        join
        idle(2);

        // fixed priority: p0 back-to-back starves p1 until p0 goes quiet
        fork
            for (int k = 0; k < 3; k++) access(1, 0, 1'b1, 32'h100 + 4*k, $urandom, 2);
            access(1, 1, 1'b0, 32'h200, 32'd0, 11);
        join
        idle(2);

        // misaligned read on port 1
        access(0, 1, 1'b0, 32'h0006, 32'd0, 1);
        idle(2);

        // reset during ACCESS of a p0 write: write lands, no done
        req[0] = 1; wr[0] = 1; addr[0] = 32'd12; wd[0] = 32'h12345678;
        idle(1);
        rst[0] = 1; req[0] = 0;
        model_mem[0][3] = 32'h12345678;
        exp_wr_cnt[0]++;
        model_rd[0] = 0; model_rd[1] = 0;
        idle(1);
        chk_zero = 2'b01;
        @(negedge clk); #1;
        chk_zero = 2'b00;
        rst[0] = 0;
        idle(2);
        access(0, 0, 1'b0, 32'd12, 32'd0, 2);
        idle(2);

        // interleaved p0 writes and p1 reads over 1000..1036
        for (int i = 0; i < 10; i++) begin
            fork
                access(0, 0, 1'b1, 32'd1000 + 4*i, $urandom, -1);
                if (i > 0) access(0, 1, 1'b0, 32'd1000 + 4*(i-1), 32'd0, -1);
            join
        end
        access(0, 1, 1'b0, 32'd1036, 32'd0, -1);
        idle(2);

        // random concurrent traffic on disjoint regions, random upper bits
        fork
            for (int k = 0; k < 25; k++) begin
                logic [31:0] a;
                a = {16'($urandom), 16'h2000 + 16'(4 * $urandom_range(0, 15))};
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                idle($urandom_range(0, 3));
                access(0, 0, 1'($urandom), a, $urandom, -1);
            end
            for (int k = 0; k < 25; k++) begin
                logic [31:0] a;
                a = {16'($urandom), 16'h3000 + 16'(4 * $urandom_range(0, 15))};
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                idle($urandom_range(0, 3));
                access(0, 1, 1'($urandom), a, $urandom, -1);
            end
        join
        idle(3);

        end_req = 1'b1;
        repeat (4) @(posedge clk);
        if (!end_done) begin
            $display("FAIL end_checks: got 0 expected 1");
            $fatal(1, "end checks not reached");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
